// File: rtl/m4_frame_sequencer.sv
// Purpose : paces frame-buffer word reads into word slots of WORD_DIV clocks, FRAME_WORDS words per frame, GROUPS frames per group.
// Latency : first bufGetWord comes WORD_DIV clocks after the IDLE exit edge; after that, one word per slot.
// Backpress: a word slot that lands while sinkReady is low waits for sinkReady and is never skipped.
//            A slot that fully elapses while waiting sets sticky overrun.
//
// Ports:
//   clk, reset (async, active-low)
//   enable       - run frames; a deassert takes effect at the next frame boundary
//   sinkReady    - downstream serializer can accept a word
//   clrErr       - pulse that clears overrun (a simultaneous set wins)
//   bufGetWord   - one-cycle strobe; the filler latches the word at bufRdPointer
//   bufRdPointer - word index within the frame
//   cntGrp       - frame index within the group
//   frameStart   - bufGetWord for word 0
//   busy         - sequencer is out of IDLE
//   overrun      - sticky flag for a missed slot
//   frameCnt     - 16-bit count of completed frames (only with SEQ_FRAME_CNT_EN)
// Configuration macro: SEQ_FRAME_CNT_EN adds the frameCnt output and its counter.
module m4_frame_sequencer #(
  parameter int WORD_DIV    = 50,
  parameter int FRAME_WORDS = 512,
  parameter int GROUPS      = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        sinkReady,
  input  logic        clrErr,
  output logic        bufGetWord,
  output logic [8:0]  bufRdPointer,
  output logic [4:0]  cntGrp,
  output logic        frameStart,
  output logic        busy,
  output logic        overrun
`ifdef SEQ_FRAME_CNT_EN
  ,
  output logic [15:0] frameCnt
`endif
);

  localparam logic [15:0] DIV_LOAD = 16'(WORD_DIV - 1);
  localparam logic [8:0]  PTR_LAST = 9'(FRAME_WORDS - 1);
  localparam logic [4:0]  GRP_LAST = 5'(GROUPS - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_SLOT = 2'd1,
    WAIT_SINK = 2'd2,
    ISSUE     = 2'd3
  } state_t;

  state_t      state;
  logic [15:0] div;
  logic        tick;
  logic        last_word;

  // The divider holds at 0 in IDLE, so gate tick with the state.
  assign tick      = (state != IDLE) && (div == 16'd0);
  assign last_word = (bufRdPointer == PTR_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      div          <= 16'd0;
      bufRdPointer <= 9'd0;
      cntGrp       <= 5'd0;
      bufGetWord   <= 1'b0;
      frameStart   <= 1'b0;
      busy         <= 1'b0;
      overrun      <= 1'b0;
`ifdef SEQ_FRAME_CNT_EN
      frameCnt     <= 16'd0;
`endif
    end else begin
      bufGetWord <= 1'b0;
      frameStart <= 1'b0;

      // When set and clear land in the same cycle, the set wins.
      if ((state == WAIT_SINK) && tick && !sinkReady)
        overrun <= 1'b1;
      else if (clrErr)
        overrun <= 1'b0;

      // Free-running slot divider outside IDLE. The state cases below may override it.
      if (state != IDLE) begin
        if (tick)
          div <= DIV_LOAD;
        else
          div <= div - 16'd1;
      end

      case (state)
        IDLE: begin
          if (enable) begin
            state        <= WAIT_SLOT;
            busy         <= 1'b1;
            div          <= DIV_LOAD;
            bufRdPointer <= 9'd0;
            cntGrp       <= 5'd0;
          end
        end

        WAIT_SLOT: begin
          if (tick) begin
            if (sinkReady) begin
              state      <= ISSUE;
              bufGetWord <= 1'b1;
              frameStart <= (bufRdPointer == 9'd0);
            end else begin
              state <= WAIT_SINK;
            end
          end
        end

        WAIT_SINK: begin
          if (sinkReady) begin
            state      <= ISSUE;
            bufGetWord <= 1'b1;
            frameStart <= (bufRdPointer == 9'd0);
            // Restart the slot grid from this late issue so that later slots shift.
            // This also keeps every word at least one full slot apart.
            div        <= DIV_LOAD;
          end
        end

        ISSUE: begin
          // The pointer and group advance only on the edge that ends ISSUE.
          // This keeps them stable for the filler during the strobe.
          if (last_word) begin
            bufRdPointer <= 9'd0;
`ifdef SEQ_FRAME_CNT_EN
            frameCnt     <= frameCnt + 16'd1;
`endif
            if (!enable) begin
              state  <= IDLE;
              busy   <= 1'b0;
              cntGrp <= 5'd0;
              div    <= 16'd0;
            end else begin
              state  <= WAIT_SLOT;
              cntGrp <= (cntGrp == GRP_LAST) ? 5'd0 : cntGrp + 5'd1;
            end
          end else begin
            bufRdPointer <= bufRdPointer + 9'd1;
            state        <= WAIT_SLOT;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
